// File: rtl/vm2002_pkg.sv
// rtl/vm2002_pkg.sv - shared coin and state types for the vm2002 coin acceptor
package vm2002_pkg;

  typedef enum logic [1:0] {
    NO_COINS = 2'd0,
    NICKEL   = 2'd1,
    DIME     = 2'd2,
    QUARTER  = 2'd3
  } coins_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    REFUND  = 2'd3
  } coin_state_t;

  // Credit value of a coin in nickel units; NO_COINS is worth nothing.
  function automatic logic [7:0] coin_units(coins_t c);
    logic [7:0] units;
    units = 8'd0;
    case (c)
      NICKEL:  units = 8'd1;
      DIME:    units = 8'd2;
      QUARTER: units = 8'd5;
      default: units = 8'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vm2002_coin_acceptor_if.sv
// rtl/vm2002_coin_acceptor_if.sv - transaction/coin interface between vending FSM and coin acceptor
interface vm2002_coin_acceptor_if;
  import vm2002_pkg::*;

  logic       start;
  logic [7:0] cost;
  logic       coin_valid;
  coins_t     coin_in;
  logic       cancel;
  logic       paid_ack;
  logic [7:0] amount;
  logic       paid;
  logic [7:0] change;
  logic       refund_valid;
  logic [7:0] refund_amount;
  logic       coin_reject;
  logic       busy;

  modport master (
    output start, cost, coin_valid, coin_in, cancel, paid_ack,
    input  amount, paid, change, refund_valid, refund_amount, coin_reject, busy
  );

  modport slave (
    input  start, cost, coin_valid, coin_in, cancel, paid_ack,
    output amount, paid, change, refund_valid, refund_amount, coin_reject, busy
  );

endinterface

// File: rtl/vm2002_timeout_timer.sv
// rtl/vm2002_timeout_timer.sv - idle-cycle counter flagging the last cycle before auto refund
module vm2002_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;

  // Holds at LAST so expired stays asserted until the owner clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/vm2002_coin_acceptor.sv
// rtl/vm2002_coin_acceptor.sv - coin acceptor: credit collection, payment, refund and timeout
module vm2002_coin_acceptor
  import vm2002_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] MAX_AMOUNT     = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  vm2002_coin_acceptor_if.slave bus
);

  coin_state_t state_q, state_d;
  logic [7:0]  amount_q, amount_d;
  logic [7:0]  cost_q, cost_d;
  logic [7:0]  change_q, change_d;
  logic [7:0]  refund_amount_q, refund_amount_d;
  logic        paid_q, paid_d;
  logic        refund_valid_q, refund_valid_d;
  logic        coin_reject_q, coin_reject_d;

  logic        timer_clear, timer_enable, timer_expired;
  logic [7:0]  units;
  logic [8:0]  sum;
  logic        accept;
  logic [7:0]  new_amount;

  vm2002_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      amount_q        <= 8'd0;
      cost_q          <= 8'd0;
      change_q        <= 8'd0;
      refund_amount_q <= 8'd0;
      paid_q          <= 1'b0;
      refund_valid_q  <= 1'b0;
      coin_reject_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      amount_q        <= amount_d;
      cost_q          <= cost_d;
      change_q        <= change_d;
      refund_amount_q <= refund_amount_d;
      paid_q          <= paid_d;
      refund_valid_q  <= refund_valid_d;
      coin_reject_q   <= coin_reject_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    amount_d        = amount_q;
    cost_d          = cost_q;
    change_d        = change_q;
    paid_d          = paid_q;
    refund_valid_d  = 1'b0;
    refund_amount_d = 8'd0;
    coin_reject_d   = 1'b0;
    timer_clear     = 1'b0;
    timer_enable    = 1'b0;
    units           = coin_units(bus.coin_in);
    sum             = {1'b0, amount_q} + {1'b0, units};
    accept          = 1'b0;
    new_amount      = amount_q;

    unique case (state_q)
      IDLE: begin
        coin_reject_d = bus.coin_valid;
        if (bus.start) begin
          state_d     = COLLECT;
          cost_d      = bus.cost;
          amount_d    = 8'd0;
          timer_clear = 1'b1;
        end
      end

      COLLECT: begin
        timer_enable  = 1'b1;
        // Cancel beats any coin in the same cycle; overflow and empty coins bounce.
        accept        = bus.coin_valid && (units != 8'd0) &&
                        (sum <= {1'b0, MAX_AMOUNT}) && !bus.cancel;
        coin_reject_d = bus.coin_valid && !accept;
        timer_clear   = accept;
        if (accept) begin
          new_amount = sum[7:0];
        end
        if (bus.cancel) begin
          state_d         = REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = amount_q;
        end else if (new_amount >= cost_q) begin
          state_d  = PAID;
          amount_d = new_amount;
          paid_d   = 1'b1;
          change_d = new_amount - cost_q;
        end else if (accept) begin
          amount_d = new_amount;
        end else if (timer_expired) begin
          state_d         = REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = amount_q;
        end
      end

      PAID: begin
        coin_reject_d = bus.coin_valid;
        if (bus.paid_ack) begin
          state_d  = IDLE;
          paid_d   = 1'b0;
          amount_d = 8'd0;
          change_d = 8'd0;
        end
      end

      REFUND: begin
        coin_reject_d = bus.coin_valid;
        state_d       = IDLE;
        amount_d      = 8'd0;
      end
    endcase
  end

  assign bus.amount        = amount_q;
  assign bus.paid          = paid_q;
  assign bus.change        = change_q;
  assign bus.refund_valid  = refund_valid_q;
  assign bus.refund_amount = refund_amount_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// tb/tb_vm2002_coin_acceptor.sv - randomized and directed bench against a behavioural acceptor model
module tb_vm2002_coin_acceptor;
  import vm2002_pkg::*;

  localparam int TMO = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cost = 8'd0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_in = 2'd0;
  logic       cancel = 1'b0;
  logic       paid_ack = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vm2002_coin_acceptor_if bus_a ();
  vm2002_coin_acceptor_if bus_b ();

  assign bus_a.start = start;  assign bus_b.start = start;
  assign bus_a.cost = cost;    assign bus_b.cost = cost;
  assign bus_a.coin_valid = coin_valid;  assign bus_b.coin_valid = coin_valid;
  assign bus_a.coin_in = coins_t'(coin_in); assign bus_b.coin_in = coins_t'(coin_in);
  assign bus_a.cancel = cancel;  assign bus_b.cancel = cancel;
  assign bus_a.paid_ack = paid_ack;  assign bus_b.paid_ack = paid_ack;

  vm2002_coin_acceptor #(.TIMEOUT_CYCLES(TMO), .MAX_AMOUNT(8'hFF)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a));
  vm2002_coin_acceptor #(.TIMEOUT_CYCLES(TMO), .MAX_AMOUNT(8'd8)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b));

  // Model phases: 0 idle, 1 collecting, 2 paid, 3 refunding.
  int unsigned p_max[2] = '{255, 8};
  int unsigned coin_val[4] = '{0, 1, 2, 5};
  int unsigned m_ph[2], m_amt[2], m_cst[2], m_idle[2];
  int unsigned e_paid[2], e_chg[2], e_rv[2], e_ra[2], e_rej[2];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_ph[i] = 0; m_amt[i] = 0; m_cst[i] = 0; m_idle[i] = 0;
    e_paid[i] = 0; e_chg[i] = 0; e_rv[i] = 0; e_ra[i] = 0; e_rej[i] = 0;
  endtask

  task automatic model_step(input int i);
    int unsigned v;
    bit ok;
    e_rv[i] = 0; e_ra[i] = 0;
    e_rej[i] = coin_valid;
    case (m_ph[i])
      0: if (start) begin
        m_ph[i] = 1; m_cst[i] = cost; m_amt[i] = 0; m_idle[i] = 0;
      end
      1: begin
        v = coin_val[coin_in];
        ok = coin_valid && v > 0 && (m_amt[i] + v <= p_max[i]) && !cancel;
        e_rej[i] = coin_valid && !ok;
        if (cancel) begin
          e_rv[i] = 1; e_ra[i] = m_amt[i]; m_ph[i] = 3;
        end else begin
          if (ok) m_amt[i] += v;
          if (m_amt[i] >= m_cst[i]) begin
            m_ph[i] = 2; e_paid[i] = 1; e_chg[i] = m_amt[i] - m_cst[i];
          end else if (ok) begin
            m_idle[i] = 0;
          end else if (m_idle[i] == TMO - 1) begin
            e_rv[i] = 1; e_ra[i] = m_amt[i]; m_ph[i] = 3;
          end else begin
            m_idle[i]++;
          end
        end
      end
      2: if (paid_ack) begin
        m_ph[i] = 0; m_amt[i] = 0; e_paid[i] = 0; e_chg[i] = 0;
      end
      default: begin
        m_ph[i] = 0; m_amt[i] = 0;
      end
    endcase
  endtask

  task automatic check_outputs(input int i);
    int unsigned amt, pd, chg, rv, ra, rej, bsy;
    if (i == 0) begin
      amt = bus_a.amount; pd = bus_a.paid; chg = bus_a.change; rv = bus_a.refund_valid;
      ra = bus_a.refund_amount; rej = bus_a.coin_reject; bsy = bus_a.busy;
    end else begin
      amt = bus_b.amount; pd = bus_b.paid; chg = bus_b.change; rv = bus_b.refund_valid;
      ra = bus_b.refund_amount; rej = bus_b.coin_reject; bsy = bus_b.busy;
    end
    check_eq($sformatf("amount[%0d]", i), amt, m_amt[i]);
    check_eq($sformatf("paid[%0d]", i), pd, e_paid[i]);
    check_eq($sformatf("change[%0d]", i), chg, e_chg[i]);
    check_eq($sformatf("refund_valid[%0d]", i), rv, e_rv[i]);
    if (e_rv[i] != 0) check_eq($sformatf("refund_amount[%0d]", i), ra, e_ra[i]);
    check_eq($sformatf("coin_reject[%0d]", i), rej, e_rej[i]);
    check_eq($sformatf("busy[%0d]", i), bsy, (m_ph[i] != 0) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      else model_step(i);
    end
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic step(input bit st, input int cs, input bit cv, input int ci,
                      input bit cn, input bit pa);
    start = st; cost = cs[7:0]; coin_valid = cv; coin_in = ci[1:0];
    cancel = cn; paid_ack = pa;
    tick();
    start = 0; coin_valid = 0; coin_in = 0; cancel = 0; paid_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int k;
    do_reset();
    check_eq("reset_amount", bus_a.amount, 0);
    check_eq("reset_busy", bus_a.busy, 0);
    check_eq("reset_refund_amount", bus_a.refund_amount, 0);

    // Four quarters against a price of 20 nickels.
    step(1, 20, 0, 0, 0, 0);
    for (int q = 0; q < 4; q++) begin
      step(0, 0, 1, 3, 0, 0);
      check_eq("r039_amount", bus_a.amount, 5 * (q + 1));
    end
    check_eq("r039_paid", bus_a.paid, 1);
    check_eq("r039_change", bus_a.change, 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("r039_idle", bus_a.busy, 0);

    // Overpay by 3 and hold paid for ten cycles.
    do_reset();
    step(1, 12, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 3, 0, 0);
    repeat (10) begin
      step(0, 0, 0, 0, 0, 0);
      check_eq("r040_paid_held", bus_a.paid, 1);
    end
    check_eq("r040_amount", bus_a.amount, 15);
    check_eq("r040_change", bus_a.change, 3);
    step(0, 0, 0, 0, 0, 1);
    check_eq("r040_paid_clear", bus_a.paid, 0);

    // Dime, nickel, cancel.
    do_reset();
    step(1, 24, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_eq("r041_refund_valid", bus_a.refund_valid, 1);
    check_eq("r041_refund_amount", bus_a.refund_amount, 3);
    step(0, 0, 0, 0, 0, 0);
    check_eq("r041_pulse_end", bus_a.refund_valid, 0);
    check_eq("r041_idle", bus_a.busy, 0);

    // Nickel then silence until the timeout refund.
    do_reset();
    step(1, 24, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    k = 0;
    while (k < TMO + 5 && bus_a.refund_valid !== 1'b1) begin
      step(0, 0, 0, 0, 0, 0);
      k++;
    end
    check_eq("r042_timeout_cycles", k, TMO);
    check_eq("r042_refund_amount", bus_a.refund_amount, 1);

    // Ceiling of 8 on instance b.
    do_reset();
    step(1, 255, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    check_eq("r043_amt5", bus_b.amount, 5);
    step(0, 0, 1, 2, 0, 0);
    check_eq("r043_amt7", bus_b.amount, 7);
    step(0, 0, 1, 3, 0, 0);
    check_eq("r043_reject", bus_b.coin_reject, 1);
    check_eq("r043_amt_kept", bus_b.amount, 7);
    step(0, 0, 1, 1, 1, 0);
    check_eq("r043_refund", bus_b.refund_amount, 7);
    check_eq("r043_coin_rejected", bus_b.coin_reject, 1);

    // Reset in the middle of collection.
    do_reset();
    step(1, 24, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    check_eq("r044_amt10", bus_a.amount, 10);
    do_reset();
    check_eq("r044_amount", bus_a.amount, 0);
    check_eq("r044_no_refund", bus_a.refund_valid, 0);
    check_eq("r044_busy", bus_a.busy, 0);

    // Zero price goes straight to paid.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("zero_cost_paid", bus_a.paid, 1);
    check_eq("zero_cost_change", bus_a.change, 0);
    step(0, 0, 0, 0, 0, 1);

    // Random traffic; the model checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) == 0,
             ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40)),
             $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 3)),
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 4) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
